demod_bit_decision: RTL and testbench

- Downstream consumer of the ten Demodulation_segment_N stages.
- Snapshots the ten per-segment signed Q16.16 correlation results on start, then accumulates them serially, one per cycle.
- Compares the sum against a threshold and emits one decided bit, plus a saturated soft metric, under the codebase start/valid/busy handshake.
- Keeps a running count of decided bits for the frame-level logic downstream.

---
 rtl/demod_bit_decision.sv | 170 +++++++++++++++++
 tb/tb_demod_bit_decision.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demod_bit_decision.sv
// Serial accumulate-and-decide stage fed by the ten demodulation segments.
// Define DEMOD_ERASURE_EN to add the erasure output and erasure band logic.
module demod_bit_decision #(
  parameter logic signed [31:0] THRESH    = 32'sd0,
  parameter logic        [31:0] ERASE_THR = 32'd32768,
  parameter int                 BIT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          segment_0,
  input  logic [31:0]          segment_1,
  input  logic [31:0]          segment_2,
  input  logic [31:0]          segment_3,
  input  logic [31:0]          segment_4,
  input  logic [31:0]          segment_5,
  input  logic [31:0]          segment_6,
  input  logic [31:0]          segment_7,
  input  logic [31:0]          segment_8,
  input  logic [31:0]          segment_9,
  output logic                 bit_out,
  output logic [31:0]          metric,
  output logic [BIT_CNT_W-1:0] bit_count,
  output logic                 valid,
  output logic                 busy
`ifdef DEMOD_ERASURE_EN
  , output logic               erasure
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic signed [35:0] SAT_MAX = 36'sh07FFFFFFF;
  localparam logic signed [35:0] SAT_MIN = 36'shF80000000;

  logic [31:0]          seg_in   [10];
  logic [31:0]          snap_reg [10];
  logic [1:0]           state_reg;
  logic [3:0]           idx_reg;
  logic signed [35:0]   acc_reg;
  logic signed [35:0]   acc_next;
  logic signed [35:0]   thresh_ext;
  logic [31:0]          cur_seg;
  logic [31:0]          metric_next;
  logic                 bit_next;
  logic                 erase_next;
  logic                 take_start;
  logic                 bit_out_reg;
  logic [31:0]          metric_reg;
  logic [BIT_CNT_W-1:0] bit_count_reg;
  logic                 valid_reg;
  logic                 busy_reg;

  assign seg_in[0] = segment_0;
  assign seg_in[1] = segment_1;
  assign seg_in[2] = segment_2;
  assign seg_in[3] = segment_3;
  assign seg_in[4] = segment_4;
  assign seg_in[5] = segment_5;
  assign seg_in[6] = segment_6;
  assign seg_in[7] = segment_7;
  assign seg_in[8] = segment_8;
  assign seg_in[9] = segment_9;

  assign take_start = (state_reg == ST_IDLE) && start;

  // Snapshot is only loaded from IDLE, so a start while busy leaves it alone.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : gen_snap
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          snap_reg[gi] <= '0;
        end else if (take_start) begin
          snap_reg[gi] <= seg_in[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    cur_seg    = snap_reg[idx_reg];
    acc_next   = acc_reg + $signed({{4{cur_seg[31]}}, cur_seg});
    thresh_ext = $signed({{4{THRESH[31]}}, THRESH});
    bit_next   = (acc_reg > thresh_ext);
    if (acc_reg > SAT_MAX) begin
      metric_next = 32'h7FFFFFFF;
    end else if (acc_reg < SAT_MIN) begin
      metric_next = 32'h80000000;
    end else begin
      metric_next = acc_reg[31:0];
    end
  end

`ifdef DEMOD_ERASURE_EN
  logic [35:0] acc_abs;
  logic        erasure_reg;

  always_comb begin
    acc_abs    = acc_reg[35] ? 36'(-acc_reg) : 36'(acc_reg);
    erase_next = (acc_abs <= {4'd0, ERASE_THR});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      erasure_reg <= 1'b0;
    end else if (state_reg == ST_DONE) begin
      erasure_reg <= erase_next;
    end
  end

  assign erasure = erasure_reg;
`else
  assign erase_next = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      acc_reg       <= '0;
      bit_out_reg   <= 1'b0;
      metric_reg    <= '0;
      bit_count_reg <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            acc_reg   <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc_reg <= acc_next;
          idx_reg <= idx_reg + 4'd1;
          if (idx_reg == 4'd9) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          // An erased decision still reports its metric but never counts.
          bit_out_reg <= bit_next && !erase_next;
          metric_reg  <= metric_next;
          if (!erase_next) begin
            bit_count_reg <= bit_count_reg + BIT_CNT_W'(1);
          end
          valid_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bit_out   = bit_out_reg;
  assign metric    = metric_reg;
  assign bit_count = bit_count_reg;
  assign valid     = valid_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_demod_bit_decision.sv
// Scoreboard bench for demod_bit_decision: expected decisions are queued at start
// and compared by a negedge monitor whenever valid pulses.
module tb_demod_bit_decision;

  localparam logic signed [31:0] THRESH    = 32'sd0;
  localparam logic        [31:0] ERASE_THR = 32'd32768;
  localparam int                 BIT_CNT_W = 16;

  typedef struct {
    logic        b;
    logic [31:0] m;
    logic [15:0] c;
    logic        e;
    int          e0;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] seg [10];
  logic        bit_out;
  logic [31:0] metric;
  logic [15:0] bit_count;
  logic        valid;
  logic        busy;
`ifdef DEMOD_ERASURE_EN
  logic        erasure;
`endif

  exp_t        q[$];
  int          n_checks;
  int          n_fail;
  int          cyc;
  logic [15:0] exp_count;

  demod_bit_decision #(
    .THRESH(THRESH), .ERASE_THR(ERASE_THR), .BIT_CNT_W(BIT_CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .segment_0(seg[0]), .segment_1(seg[1]), .segment_2(seg[2]), .segment_3(seg[3]),
    .segment_4(seg[4]), .segment_5(seg[5]), .segment_6(seg[6]), .segment_7(seg[7]),
    .segment_8(seg[8]), .segment_9(seg[9]),
    .bit_out(bit_out), .metric(metric), .bit_count(bit_count),
    .valid(valid), .busy(busy)
`ifdef DEMOD_ERASURE_EN
    , .erasure(erasure)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_checks = n_checks + 1;
      if (q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected_valid cycle=%0d bit_out=%0b metric=%08h", cyc, bit_out, metric);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bit_out !== e.b || metric !== e.m || bit_count !== e.c || cyc !== e.e0 + 11) begin
          n_fail = n_fail + 1;
          $display("FAIL decision got bit=%0b metric=%08h count=%0d cycle=%0d want bit=%0b metric=%08h count=%0d cycle=%0d",
                   bit_out, metric, bit_count, cyc, e.b, e.m, e.c, e.e0 + 11);
        end else begin
          $display("decision ok bit=%0b metric=%08h count=%0d cycle=%0d", bit_out, metric, bit_count, cyc);
        end
`ifdef DEMOD_ERASURE_EN
        n_checks = n_checks + 1;
        if (erasure !== e.e) begin
          n_fail = n_fail + 1;
          $display("FAIL erasure got %0b want %0b", erasure, e.e);
        end
`endif
      end
    end
  end

  // Caller is 1 time unit after a negedge; start is sampled at the next posedge.
  task automatic kick(input bit do_push);
    longint sum;
    longint a;
    exp_t   e;
    sum = 0;
    for (int i = 0; i < 10; i++) sum += longint'($signed(seg[i]));
    if (sum > 64'sd2147483647)       e.m = 32'h7FFFFFFF;
    else if (sum < -64'sd2147483648) e.m = 32'h80000000;
    else                             e.m = 32'(sum);
    a   = (sum < 0) ? -sum : sum;
    e.e = 1'b0;
`ifdef DEMOD_ERASURE_EN
    e.e = (a <= longint'(ERASE_THR));
`endif
    e.b = (sum > longint'(THRESH)) && !e.e;
    if (do_push) begin
      if (!e.e) exp_count = exp_count + 16'd1;
      e.c  = exp_count;
      e.e0 = cyc + 1;
      q.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    #1;
    n_checks = n_checks + 1;
    if (q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_timeout pending=%0d want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < 10; i++) seg[i] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks = n_checks + 1;
    if ({bit_out, metric, bit_count, valid, busy} !== 51'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_state got bit=%0b metric=%08h count=%0d valid=%0b busy=%0b want all 0",
               bit_out, metric, bit_count, valid, busy);
    end else $display("reset ok");
    reset = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_all_pos();
    set_all(32'd65536);
    kick(1'b1);
    for (int k = 0; k < 11; k++) begin
      n_checks = n_checks + 1;
      if (busy !== 1'b1 || valid !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL busy_window step=%0d got busy=%0b valid=%0b want busy=1 valid=0", k, busy, valid);
      end
      if (k < 10) begin
        @(negedge clk);
        #1;
      end
    end
    @(negedge clk);
    #1;
    n_checks = n_checks + 1;
    if (busy !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL busy_release got %0b want 0", busy);
    end
    wait_drain("all_pos");
  endtask

  task automatic test_pattern(input string name, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 10; i++) seg[i] = (i % 2 == 0) ? a : b;
    kick(1'b1);
    wait_drain(name);
  endtask

  task automatic test_ignored_start();
    set_all(32'd98304);
    kick(1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (k == 1) for (int i = 0; i < 10; i++) seg[i] = $urandom;
      start = (k == 2 || k == 6);
    end
    start = 1'b0;
    wait_drain("ignored_start");
    repeat (14) @(negedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    t1 = -1;
    t2 = -1;
    set_all(32'hFFFF8000);
    kick(1'b1);
    for (int n = 0; n < 20 && t1 < 0; n++) begin
      @(negedge clk);
      if (valid === 1'b1) t1 = cyc;
    end
    #1;
    set_all(32'd12345);
    kick(1'b1);
    for (int n = 0; n < 20 && t2 < 0; n++) begin
      @(negedge clk);
      if (valid === 1'b1) t2 = cyc;
    end
    #1;
    n_checks = n_checks + 1;
    if (t1 < 0 || t2 - t1 != 12) begin
      n_fail = n_fail + 1;
      $display("FAIL back_to_back spacing got %0d want 12", t2 - t1);
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_reset_abort();
    set_all(32'd65536);
    kick(1'b0);
    repeat (4) @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_checks = n_checks + 1;
    if ({bit_out, metric, bit_count, valid, busy} !== 51'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL abort_reset got bit=%0b metric=%08h count=%0d valid=%0b busy=%0b want all 0",
               bit_out, metric, bit_count, valid, busy);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    exp_count = 16'd0;
    repeat (15) @(negedge clk);
    #1;
    kick(1'b1);
    wait_drain("after_abort");
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 16'd0;
    start     = 1'b0;
    reset     = 1'b1;
    set_all(32'd0);
    test_reset();
    test_all_pos();
    test_pattern("all_neg", 32'hFFFF0000, 32'hFFFF0000);
    test_pattern("alternating", 32'd65536, 32'hFFFF0000);
    test_pattern("sat_pos", 32'h7FFFFFFF, 32'h7FFFFFFF);
    test_pattern("sat_neg", 32'h80000000, 32'h80000000);
    test_pattern("small_mix", 32'd40000, 32'hFFFFD000);
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
